// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus access controller: turns a Memory-stage request into
// one bus transaction, presents completed load data to the pipeline, and
// raises a sticky error when the bus stalls a transaction for too long.

package mem_access_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

// state | meaning
// IDLE  | no transaction in flight; accept a new unflushed request
// ADDR  | request presented on dreq, waiting for addr_ok
// DATA  | address accepted, waiting for data_ok
// HOLD  | access complete, rdata valid until the pipeline advances or flushes
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  dbus_req_t   m_req,
    input  logic        advance,
    input  logic        flush,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err
);

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;
    logic        dreq_valid;
    logic        drop;
    logic [15:0] wait_cnt;

    logic        waiting;
    logic        capture;
    logic        complete;
    logic        drop_eff;

    logic        dreq_valid_nxt;
    logic        rdata_valid_nxt;
    logic        drop_nxt;
    logic        err_nxt;
    logic [15:0] wait_cnt_nxt;

    // State register plus all registered outputs and the request register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            req_addr    <= '0;
            req_size    <= '0;
            req_strobe  <= '0;
            req_data    <= '0;
            dreq_valid  <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            drop        <= 1'b0;
            wait_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            if (capture) begin
                req_addr   <= m_req.addr;
                req_size   <= m_req.size;
                req_strobe <= m_req.strobe;
                req_data   <= m_req.data;
            end
            // Stores latch too; the value is simply meaningless to the pipeline
            if (complete) begin
                rdata <= dresp.data;
            end
            dreq_valid  <= dreq_valid_nxt;
            rdata_valid <= rdata_valid_nxt;
            drop        <= drop_nxt;
            wait_cnt    <= wait_cnt_nxt;
            err         <= err_nxt;
        end
    end

    // Next-state: a flushed transaction still finishes its handshake, then skips HOLD
    always_comb begin
        waiting   = (state == S_ADDR) || (state == S_DATA);
        drop_eff  = drop || flush;
        capture   = 1'b0;
        complete  = 1'b0;
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (m_req.valid && !flush) begin
                    capture   = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (dresp.addr_ok && dresp.data_ok) begin
                    complete = 1'b1;
                end else if (dresp.addr_ok) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (dresp.data_ok) begin
                    complete = 1'b1;
                end
            end
            S_HOLD: begin
                if (advance || flush) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (complete) begin
            state_nxt = drop_eff ? S_IDLE : S_HOLD;
        end
    end

    // Output/datapath next values, registered above so outputs never glitch
    always_comb begin
        dreq_valid_nxt  = (state_nxt == S_ADDR);
        rdata_valid_nxt = (state_nxt == S_HOLD);

        if (state_nxt == S_IDLE) begin
            drop_nxt = 1'b0;
        end else if (waiting && flush) begin
            drop_nxt = 1'b1;
        end else begin
            drop_nxt = drop;
        end

        if (capture) begin
            wait_cnt_nxt = '0;
        end else if (waiting && (wait_cnt != TIMEOUT_C)) begin
            wait_cnt_nxt = wait_cnt + 16'd1;
        end else begin
            wait_cnt_nxt = wait_cnt;
        end

        // Timeout only reports; the handshake keeps waiting
        err_nxt = err || (waiting && (wait_cnt_nxt == TIMEOUT_C));
    end

    assign dreq = '{valid:  dreq_valid,
                    addr:   req_addr,
                    size:   req_size,
                    strobe: req_strobe,
                    data:   req_data};

    assign stall = m_req.valid && (state != S_HOLD);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    dbus_req_t   m_req;
    logic        advance;
    logic        flush;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m_req       (m_req),
        .advance     (advance),
        .flush       (flush),
        .dreq        (dreq),
        .dresp       (dresp),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Reference model: one outstanding transaction tracked by plain flags
    bit          m_busy     = 0;
    bit          m_accepted = 0;
    bit          m_dropped  = 0;
    bit          m_holding  = 0;
    bit          m_err      = 0;
    bit          m_is_load  = 0;
    int          m_waited   = 0;
    logic [31:0] m_addr     = '0;
    logic [1:0]  m_size     = '0;
    logic [3:0]  m_strobe   = '0;
    logic [31:0] m_data     = '0;
    logic [31:0] m_rdata    = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 0; m_accepted = 0; m_dropped = 0; m_holding = 0;
            m_err = 0; m_is_load = 0; m_waited = 0;
            m_addr = '0; m_size = '0; m_strobe = '0; m_data = '0; m_rdata = '0;
        end else if (m_holding) begin
            if (advance || flush) m_holding = 0;
        end else if (!m_busy) begin
            if (m_req.valid && !flush) begin
                m_busy = 1; m_accepted = 0; m_dropped = 0; m_waited = 0;
                m_addr = m_req.addr; m_size = m_req.size;
                m_strobe = m_req.strobe; m_data = m_req.data;
                m_is_load = (m_req.strobe == 4'b0000);
            end
        end else begin
            m_waited++;
            if (m_waited >= TMO) m_err = 1;
            if (flush) m_dropped = 1;
            if ((!m_accepted && dresp.addr_ok && dresp.data_ok) ||
                (m_accepted && dresp.data_ok)) begin
                m_busy = 0;
                if (!m_dropped) m_holding = 1;
                if (m_is_load) m_rdata = dresp.data;
            end else if (!m_accepted && dresp.addr_ok) begin
                m_accepted = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk1("stall", stall, m_req.valid && !m_holding);
        chk1("dreq_valid", dreq.valid, m_busy && !m_accepted);
        chk1("rdata_valid", rdata_valid, m_holding);
        chk1("err", err, m_err);
        if (m_busy && !m_accepted) begin
            chk("dreq_addr", dreq.addr, m_addr);
            chk("dreq_size", {30'b0, dreq.size}, {30'b0, m_size});
            chk("dreq_strobe", {28'b0, dreq.strobe}, {28'b0, m_strobe});
            chk("dreq_data", dreq.data, m_data);
        end
        if (m_holding && m_is_load) chk("rdata", rdata, m_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
        m_req = '{valid: v, addr: a, size: 2'd2, strobe: s, data: d};
    endtask

    task automatic set_resp(input logic aok, input logic dok, input logic [31:0] d);
        dresp = '{addr_ok: aok, data_ok: dok, data: d};
    endtask

    initial begin
        int nv;
        advance = 1'b0;
        flush   = 1'b0;
        set_req(1'b1, 32'h0000_0001, 4'h0, 32'h0);
        set_resp(1'b0, 1'b0, 32'h0);

        // Reset state
        step(); step();
        chk1("rst_dreq_valid", dreq.valid, 1'b0);
        chk("rst_dreq_addr", dreq.addr, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk1("rst_rdata_valid", rdata_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_stall", stall, 1'b1);
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        resetn = 1'b1;
        step();

        // Single-cycle load: rdata_valid and stall release in cycle 3
        set_req(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        step();
        chk1("ld_dreq_valid_c2", dreq.valid, 1'b1);
        chk("ld_dreq_addr_c2", dreq.addr, 32'h8000_0010);
        set_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        chk1("ld_rdata_valid_c3", rdata_valid, 1'b1);
        chk("ld_rdata_c3", rdata, 32'hDEAD_BEEF);
        chk1("ld_stall_c3", stall, 1'b0);
        chk1("ld_dreq_valid_c3", dreq.valid, 1'b0);
        advance = 1'b1;
        step();
        advance = 1'b0;
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Long HOLD without advance, left through flush
        set_req(1'b1, 32'h0000_0100, 4'h0, 32'h0);
        step();
        set_resp(1'b1, 1'b1, 32'hCAFE_F00D);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("hold_rdata_valid", rdata_valid, 1'b1);
            chk1("hold_stall", stall, 1'b0);
            chk1("hold_dreq_valid", dreq.valid, 1'b0);
            chk("hold_rdata", rdata, 32'hCAFE_F00D);
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk1("hold_flush_rdata_valid", rdata_valid, 1'b0);
        step();

        // Store with delayed addr_ok (4 ADDR cycles) and data_ok two cycles later
        set_req(1'b1, 32'h2000_0000, 4'hF, 32'h1234_5678);
        nv = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            if (dreq.valid) nv++;
            step();
        end
        if (dreq.valid) nv++;
        set_resp(1'b1, 1'b0, 32'h0);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        #1;
        chk1("st_stall_data", stall, 1'b1);
        step();
        set_resp(1'b0, 1'b1, 32'hFFFF_FFFF);
        #1;
        chk1("st_stall_dataok", stall, 1'b1);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        chk("st_addr_cycles", nv, 32'd4);
        #1;
        chk1("st_stall_hold", stall, 1'b0);
        chk1("st_rdata_valid", rdata_valid, 1'b1);
        advance = 1'b1;
        step();
        advance = 1'b0;
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Flush while in DATA: finish quietly, back to IDLE after data_ok
        set_req(1'b1, 32'h0000_3000, 4'h0, 32'h0);
        step();
        set_resp(1'b1, 1'b0, 32'h0);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        step();
        flush = 1'b0;
        set_resp(1'b0, 1'b1, 32'h0000_0055);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        chk1("fl_rdata_valid", rdata_valid, 1'b0);
        chk1("fl_dreq_valid", dreq.valid, 1'b0);
        set_req(1'b1, 32'h0000_3100, 4'h0, 32'h0);
        #1;
        chk1("fl_idle_stall", stall, 1'b1);
        step();
        chk1("fl_next_dreq_valid", dreq.valid, 1'b1);
        set_resp(1'b1, 1'b1, 32'h0000_0066);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        chk("fl_next_rdata", rdata, 32'h0000_0066);
        advance = 1'b1;
        step();
        advance = 1'b0;

        // Flush in IDLE: request is not taken
        set_req(1'b1, 32'h0000_5000, 4'h0, 32'h0);
        flush = 1'b1;
        step();
        chk1("fl_idle_no_dreq", dreq.valid, 1'b0);
        flush = 1'b0;
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Timeout: err after 8 wait cycles, transaction then completes normally
        set_req(1'b1, 32'h0000_4000, 4'h0, 32'h0);
        step();
        for (int i = 0; i < 7; i++) step();
        chk1("tmo_err_before", err, 1'b0);
        step();
        chk1("tmo_err_set", err, 1'b1);
        chk1("tmo_dreq_valid", dreq.valid, 1'b1);
        set_resp(1'b1, 1'b1, 32'h0000_0077);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        chk1("tmo_err_sticky", err, 1'b1);
        chk("tmo_rdata", rdata, 32'h0000_0077);
        chk1("tmo_rdata_valid", rdata_valid, 1'b1);
        advance = 1'b1;
        step();
        advance = 1'b0;

        // Asynchronous reset in the middle of ADDR
        set_req(1'b1, 32'h0000_6000, 4'h0, 32'h0);
        step();
        chk1("ar_dreq_valid_before", dreq.valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk1("ar_dreq_valid", dreq.valid, 1'b0);
        chk("ar_rdata", rdata, 32'h0);
        chk1("ar_err", err, 1'b0);
        chk1("ar_rdata_valid", rdata_valid, 1'b0);
        step();
        resetn = 1'b1;
        #1;
        chk1("ar_stall_after", stall, 1'b1);
        step();
        chk1("ar_restart_dreq_valid", dreq.valid, 1'b1);
        set_resp(1'b1, 1'b1, 32'h0000_0099);
        step();
        set_resp(1'b0, 1'b0, 32'h0);
        chk("ar_restart_rdata", rdata, 32'h0000_0099);
        advance = 1'b1;
        step();
        advance = 1'b0;
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
